// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with stall/flush, valid-gated side effects,
// registered branch-taken flag and saturating bubble/stall counters.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RA_W   = 5,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              perf_clr,
  input  logic              e_valid,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic              ebranch,
  input  logic              ezero,
  input  logic [DATA_W-1:0] ealuout,
  input  logic [DATA_W-1:0] edata_b,
  input  logic [RA_W-1:0]   erdrt,
  input  logic [PC_W-1:0]   epc,
  input  logic [TAG_W-1:0]  e_ins_type,
  input  logic [TAG_W-1:0]  e_ins_number,
  output logic              m_valid,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic              mbranch,
  output logic              mzero,
  output logic [DATA_W-1:0] maluout,
  output logic [DATA_W-1:0] mdata_b,
  output logic [RA_W-1:0]   mrdrt,
  output logic [PC_W-1:0]   mpc,
  output logic [TAG_W-1:0]  m_ins_type,
  output logic [TAG_W-1:0]  m_ins_number,
  output logic              m_taken,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Valid semantics: e_valid marks a real instruction in EXE; it is captured
  // into m_valid on a load and gates every control that writes state or
  // redirects the PC, so an invalid slot is inert downstream.
  logic bubble_ev;
  logic stall_ev;

  assign bubble_ev = flush | (~stall & ~e_valid);
  assign stall_ev  = stall & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid      <= 1'b0;
      mwreg        <= 1'b0;
      mm2reg       <= 1'b0;
      mwmem        <= 1'b0;
      mbranch      <= 1'b0;
      mzero        <= 1'b0;
      m_taken      <= 1'b0;
      maluout      <= '0;
      mdata_b      <= '0;
      mrdrt        <= '0;
      mpc          <= '0;
      m_ins_type   <= '0;
      m_ins_number <= '0;
    end else if (flush) begin
      // Bubble: kill controls and tag it as NOP; data fields simply hold.
      m_valid    <= 1'b0;
      mwreg      <= 1'b0;
      mm2reg     <= 1'b0;
      mwmem      <= 1'b0;
      mbranch    <= 1'b0;
      mzero      <= 1'b0;
      m_taken    <= 1'b0;
      m_ins_type <= '0;
    end else if (!stall) begin
      m_valid      <= e_valid;
      mwreg        <= ewreg & e_valid;
      mm2reg       <= em2reg & e_valid;
      mwmem        <= ewmem & e_valid;
      mbranch      <= ebranch & e_valid;
      mzero        <= ezero;
      m_taken      <= ebranch & ezero & e_valid;
      maluout      <= ealuout;
      mdata_b      <= edata_b;
      mrdrt        <= erdrt;
      mpc          <= epc;
      m_ins_type   <= e_ins_type;
      m_ins_number <= e_ins_number;
    end
  end

  // Counters stick at all-ones; perf_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble_ev && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
      if (stall_ev && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg, counters narrowed to 3 bits so that
// saturation is reachable quickly.
module tb_exe_mem_pipe_reg;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int RA_W   = 5;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n, stall, flush, perf_clr;
  logic              e_valid, ewreg, em2reg, ewmem, ebranch, ezero;
  logic [DATA_W-1:0] ealuout, edata_b;
  logic [RA_W-1:0]   erdrt;
  logic [PC_W-1:0]   epc;
  logic [TAG_W-1:0]  e_ins_type, e_ins_number;
  logic              m_valid, mwreg, mm2reg, mwmem, mbranch, mzero, m_taken;
  logic [DATA_W-1:0] maluout, mdata_b;
  logic [RA_W-1:0]   mrdrt;
  logic [PC_W-1:0]   mpc;
  logic [TAG_W-1:0]  m_ins_type, m_ins_number;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  int checks;
  int failures;
  logic [DATA_W-1:0] exp_q[$];

  exe_mem_pipe_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .e_valid(e_valid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ebranch(ebranch), .ezero(ezero), .ealuout(ealuout), .edata_b(edata_b),
    .erdrt(erdrt), .epc(epc), .e_ins_type(e_ins_type), .e_ins_number(e_ins_number),
    .m_valid(m_valid), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mbranch(mbranch), .mzero(mzero), .maluout(maluout), .mdata_b(mdata_b),
    .mrdrt(mrdrt), .mpc(mpc), .m_ins_type(m_ins_type), .m_ins_number(m_ins_number),
    .m_taken(m_taken), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_exe(input logic v, input logic wr, input logic wm,
                           input logic br, input logic z,
                           input logic [DATA_W-1:0] alu,
                           input logic [TAG_W-1:0] typ);
    e_valid    = v;
    ewreg      = wr;
    ewmem      = wm;
    ebranch    = br;
    ezero      = z;
    ealuout    = alu;
    e_ins_type = typ;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the ALU result path: expectations are queued in order.
  task automatic check_alu(input string tag);
    logic [DATA_W-1:0] e;
    e = exp_q.pop_front();
    check(tag, 64'(maluout), 64'(e));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    em2reg = 1'b0; edata_b = 32'h0; erdrt = '0; epc = 32'h0; e_ins_number = '0;
    drive_exe(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h7);
    erdrt = 5'd9; epc = 32'h100; e_ins_number = 4'h3;

    // Reset: everything cleared even though EXE holds a valid instruction
    steps(2);
    exp_q.push_back(32'h0);
    check_alu("rst_maluout");
    check("rst_ctrl", {60'h0, m_valid, mwreg, mwmem, m_taken}, 64'h0);
    check("rst_mrdrt_mpc", {mrdrt, mpc}, 64'h0);
    check("rst_tags", {m_ins_type, m_ins_number, mzero}, 64'h0);
    check("rst_cnts", {bubble_cnt, stall_cnt}, 64'h0);

    // First load after reset
    rst_n = 1'b1;
    drive_exe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, 4'h1);
    erdrt = 5'd5;
    step();
    exp_q.push_back(32'hA5);
    check_alu("load_maluout");
    check("load_mwreg_mvalid", {mwreg, m_valid}, 2'b11);
    check("load_mrdrt", mrdrt, 5'd5);
    check("load_cnts", {bubble_cnt, stall_cnt}, 64'h0);

    // Stall hold for 3 edges, then release
    ealuout = 32'h1234;
    step();
    stall = 1'b1;
    ealuout = 32'hFFFF;
    steps(3);
    exp_q.push_back(32'h1234);
    check_alu("stall_hold_maluout");
    check("stall_cnt_3", stall_cnt, 3'd3);
    check("stall_bubble_0", bubble_cnt, 3'd0);
    stall = 1'b0;
    step();
    exp_q.push_back(32'hFFFF);
    check_alu("stall_release_maluout");

    // Valid branch-taken entry, then flush together with stall
    drive_exe(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 4'h5);
    step();
    check("taken_entry", {mwmem, mbranch, mzero, m_taken, m_ins_type}, {4'b1111, 4'h5});
    stall = 1'b1; flush = 1'b1; ealuout = 32'h99;
    step();
    check("flush_ctrl", {m_valid, mwmem, mbranch, mzero, m_taken}, 5'b0);
    check("flush_type", m_ins_type, 4'h0);
    exp_q.push_back(32'h55);
    check_alu("flush_maluout_hold");
    check("flush_bubble_cnt", bubble_cnt, 3'd1);
    check("flush_stall_cnt", stall_cnt, 3'd3);

    // Invalid slot cannot write or redirect
    stall = 1'b0; flush = 1'b0;
    drive_exe(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 4'h2);
    step();
    check("inv_gating", {m_valid, mwreg, mwmem, mbranch, m_taken}, 5'b0);
    check("inv_mzero", mzero, 1'b1);
    check("inv_bubble_cnt", bubble_cnt, 3'd2);
    exp_q.push_back(32'h77);
    check_alu("inv_maluout");

    // Two-cycle flush: two bubbles
    flush = 1'b1;
    drive_exe(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88, 4'h6);
    steps(2);
    check("mflush_bubble_cnt", bubble_cnt, 3'd4);
    check("mflush_valid", {m_valid, m_taken}, 2'b00);
    flush = 1'b0;

    // Stall counter saturation, then clear with stall
    stall = 1'b1;
    steps(10);
    check("stall_sat", stall_cnt, 3'd7);
    exp_q.push_back(32'h77);
    check_alu("stall_sat_hold");
    perf_clr = 1'b1;
    step();
    check("clr_stall_cnt", stall_cnt, 3'd0);
    check("clr_bubble_cnt", bubble_cnt, 3'd0);
    perf_clr = 1'b0;
    step();
    check("post_clr_stall", stall_cnt, 3'd1);

    // Bubble counter saturation via long flush
    flush = 1'b1;
    steps(9);
    check("bubble_sat", bubble_cnt, 3'd7);
    check("bubble_sat_stall", stall_cnt, 3'd1);

    // Reset mid-stall, then normal load
    flush = 1'b0; stall = 1'b1; rst_n = 1'b0;
    step();
    exp_q.push_back(32'h0);
    check_alu("midrst_maluout");
    check("midrst_cnts", {bubble_cnt, stall_cnt}, 64'h0);
    rst_n = 1'b1; stall = 1'b0;
    drive_exe(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 4'h4);
    step();
    exp_q.push_back(32'h42);
    check_alu("after_rst_load");
    check("after_rst_taken", {m_valid, m_taken, m_ins_type}, {2'b11, 4'h4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
